// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, reset constants and payload/state types for the MIPS pipeline registers
package mips_pipe_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WE_WIDTH = 1;
  localparam int DATA_WIDTH = 32;
  localparam int ALUOP_WIDTH = 8;
  localparam int PC_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic [PC_WIDTH-1:0] INITIAL_PC = 32'h0;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] wd;
    logic [WE_WIDTH-1:0] wreg;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ALUOP_WIDTH-1:0] aluop;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] reg2;
    logic [PC_WIDTH-1:0] pc;
  } ex_mem_payload_t;
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry skid buffer with registered in_ready and synchronous flush
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_t state_q, state_d;
  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  logic ready_q;
  logic in_fire, out_fire;
  assign in_fire = in_valid & ready_q;
  assign out_fire = out_valid & out_ready;
  assign in_ready = ready_q;
  assign out_valid = state_q != SKID_EMPTY;
  assign out_data = out_q;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_ONE;
          out_d = in_data;
        end
      end
      SKID_ONE: begin
        if (in_fire && !out_fire) begin
          state_d = SKID_FULL;
          skid_d = in_data;
        end else if (in_fire) begin
          out_d = in_data;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d = SKID_ONE;
          out_d = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) state_d = SKID_EMPTY;
  end
  // ready is recomputed from the next state so it leaves a flop, never a comb path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      out_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
      ready_q <= state_d != SKID_FULL;
    end
  end
endmodule

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: elastic EX->MEM pipeline register with flush, writeback gating and bubble counter
module ex_mem_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_WIDTH,
  parameter int WE_W = WE_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int ALUOP_W = ALUOP_WIDTH,
  parameter int PC_W = PC_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(INITIAL_PC),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic [WE_W-1:0]       in_wreg,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [DATA_W-1:0]     in_reg2,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic [WE_W-1:0]       out_wreg,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_reg2,
  output logic [PC_W-1:0]       out_pc,
  output logic [CNT_W-1:0]      bubble_cnt
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic [WE_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] reg2;
    logic [PC_W-1:0] pc;
  } payload_t;
  payload_t in_p, out_p;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  assign in_p = '{wd: in_wd, wreg: in_wreg, wdata: in_wdata, aluop: in_aluop,
                  mem_addr: in_mem_addr, reg2: in_reg2, pc: in_pc};
  pipe_skid_buf #(.W($bits(payload_t))) u_skid (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_p)
  );
  // an empty stage must never look like a regfile write to MEM/WB
  assign out_wd = out_valid ? out_p.wd : '0;
  assign out_wreg = out_valid ? out_p.wreg : '0;
  assign out_pc = out_valid ? out_p.pc : RESET_PC;
  assign out_wdata = out_p.wdata;
  assign out_aluop = out_p.aluop;
  assign out_mem_addr = out_p.mem_addr;
  assign out_reg2 = out_p.reg2;
  assign bubble_cnt = bubble_q;
  always_comb begin
    bubble_d = (out_ready && !out_valid && !(&bubble_q)) ? bubble_q + CNT_W'(1) : bubble_q;
  end
  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else bubble_q <= bubble_d;
  end
endmodule
